// File: rtl/clint_prio_if.sv
// Bundles the interrupt inputs, pipeline hooks and CSR write-back signals
// of the core-local interrupt controller. The slave side is the controller.
interface clint_prio_if #(
    parameter int XLEN  = 16,
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_en;
    logic             global_int_en;
    logic [XLEN-1:0]  inst_addr;
    logic             mret_flag;
    logic             jump_flag;
    logic [XLEN-1:0]  jump_addr;
    logic [XLEN-1:0]  csr_mtvec;
    logic [XLEN-1:0]  csr_mepc;
    logic [XLEN-1:0]  csr_mstatus;
    logic             clear_flag;
    logic [2:0]       int_we;
    logic [XLEN-1:0]  int_mepc;
    logic [XLEN-1:0]  int_mcause;
    logic [XLEN-1:0]  int_mstatus;
    logic [XLEN-1:0]  int_inst_addr;
    logic             int_assert;
    logic [N_IRQ-1:0] irq_ack;

    modport slave (
        input  irq, irq_en, global_int_en, inst_addr, mret_flag, jump_flag,
               jump_addr, csr_mtvec, csr_mepc, csr_mstatus,
        output clear_flag, int_we, int_mepc, int_mcause, int_mstatus,
               int_inst_addr, int_assert, irq_ack
    );

    modport master (
        output irq, irq_en, global_int_en, inst_addr, mret_flag, jump_flag,
               jump_addr, csr_mtvec, csr_mepc, csr_mstatus,
        input  clear_flag, int_we, int_mepc, int_mcause, int_mstatus,
               int_inst_addr, int_assert, irq_ack
    );
endinterface

// File: rtl/clint_prio.sv
// clint_prio: prioritised core-local interrupt controller.
// Edge-captures N_IRQ sources, picks the lowest enabled pending index,
// saves mepc/mcause/mstatus, redirects EX to mtvec, and handles mret.
// Optional feature: define CLINT_VECTORED_EN for vectored mtvec mode.
//
// state  | meaning
// S_IDLE | waiting for mret or an enabled pending interrupt
// S_SAVE | writing mepc/mcause/mstatus
// S_JUMP | redirecting EX to the handler, acknowledging the source
// S_MRET | restoring mstatus.MIE from MPIE
// S_MRTJ | redirecting EX back to mepc
module clint_prio #(
    parameter int XLEN       = 16,
    parameter int N_IRQ      = 8,
    parameter int CAUSE_BASE = 16,
    parameter int VEC_SHIFT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    clint_prio_if.slave bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_JUMP, S_MRET, S_MRTJ
    } state_t;

    state_t           state, state_nxt;
    logic [N_IRQ-1:0] irq_q, pending, req;
    logic [N_IRQ-1:0] ack_q, ack_nxt;
    logic [ID_W-1:0]  win, id_q;
    logic             take, capture;
    logic [XLEN-2:0]  cause_code;
    logic [XLEN-1:0]  epc_sel, target, ms_save, ms_mret;
    logic [2:0]       we_q, we_nxt;
    logic [XLEN-1:0]  mepc_q, mepc_nxt, mcause_q, mcause_nxt;
    logic [XLEN-1:0]  mstatus_q, mstatus_nxt, addr_q, addr_nxt;
    logic             assert_q, assert_nxt;

    assign req        = pending & bus.irq_en;
    assign take       = (|req) & bus.global_int_en;
    assign cause_code = (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(win);
    assign epc_sel    = bus.jump_flag ? bus.jump_addr : bus.inst_addr;

    // lowest set index of req wins
    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) win = ID_W'(i);
        end
    end

`ifdef CLINT_VECTORED_EN
    // handler target: base, plus per-source stride in vectored mode
    always_comb begin
        target = bus.csr_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
        if (bus.csr_mtvec[1:0] == 2'b01) begin
            target = target + (XLEN'(id_q) << VEC_SHIFT);
        end
    end
`else
    assign target = bus.csr_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
`endif

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret (MIE<=MPIE, MPIE<=1)
    always_comb begin
        ms_save    = bus.csr_mstatus;
        ms_save[7] = bus.csr_mstatus[3];
        ms_save[3] = 1'b0;
        ms_mret    = bus.csr_mstatus;
        ms_mret[3] = bus.csr_mstatus[7];
        ms_mret[7] = 1'b1;
    end

    // next state and the registered outputs that belong to it
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        we_nxt      = 3'b000;
        mepc_nxt    = '0;
        mcause_nxt  = '0;
        mstatus_nxt = '0;
        addr_nxt    = '0;
        assert_nxt  = 1'b0;
        ack_nxt     = '0;
        case (state)
            S_IDLE: begin
                if (bus.mret_flag) begin
                    state_nxt   = S_MRET;
                    we_nxt      = 3'b001;
                    mstatus_nxt = ms_mret;
                end else if (take) begin
                    state_nxt   = S_SAVE;
                    capture     = 1'b1;
                    we_nxt      = 3'b111;
                    mepc_nxt    = epc_sel;
                    mcause_nxt  = {1'b1, cause_code};
                    mstatus_nxt = ms_save;
                end
            end
            S_SAVE: begin
                state_nxt  = S_JUMP;
                assert_nxt = 1'b1;
                addr_nxt   = target;
                ack_nxt    = N_IRQ'(1) << id_q;
            end
            S_MRET: begin
                state_nxt  = S_MRTJ;
                assert_nxt = 1'b1;
                addr_nxt   = bus.csr_mepc;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // state, edge capture, pending bits and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            irq_q     <= '0;
            pending   <= '0;
            id_q      <= '0;
            we_q      <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mstatus_q <= '0;
            addr_q    <= '0;
            assert_q  <= 1'b0;
            ack_q     <= '0;
        end else begin
            state     <= state_nxt;
            irq_q     <= bus.irq;
            pending   <= (pending & ~ack_q) | (bus.irq & ~irq_q);
            if (capture) id_q <= win;
            we_q      <= we_nxt;
            mepc_q    <= mepc_nxt;
            mcause_q  <= mcause_nxt;
            mstatus_q <= mstatus_nxt;
            addr_q    <= addr_nxt;
            assert_q  <= assert_nxt;
            ack_q     <= ack_nxt;
        end
    end

    assign bus.clear_flag    = (state != S_IDLE) | bus.mret_flag | take;
    assign bus.int_we        = we_q;
    assign bus.int_mepc      = mepc_q;
    assign bus.int_mcause    = mcause_q;
    assign bus.int_mstatus   = mstatus_q;
    assign bus.int_inst_addr = addr_q;
    assign bus.int_assert    = assert_q;
    assign bus.irq_ack       = ack_q;
endmodule

// File: tb/tb_clint_prio.sv
// Self-checking bench for clint_prio: expected CSR-write and redirect
// beats are queued as stimulus is applied and compared as they appear.
module tb_clint_prio;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clint_prio_if #(.XLEN(16), .N_IRQ(8)) bus ();

    clint_prio #(.XLEN(16), .N_IRQ(8), .CAUSE_BASE(16), .VEC_SHIFT(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  we;
        logic [15:0] mepc;
        logic [15:0] mcause;
        logic [15:0] mstatus;
        logic [15:0] addr;
        logic        asrt;
        logic [7:0]  ack;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_target(input logic [15:0] mtvec, input int src);
        logic [15:0] base;
        base = {mtvec[15:2], 2'b00};
`ifdef CLINT_VECTORED_EN
        if (mtvec[1:0] == 2'b01) return base + 16'(src * 4);
`endif
        return base;
    endfunction

    task automatic push_save(input int c, input int src, input logic [15:0] epc,
                             input logic [15:0] ms);
        exp_t x;
        x.cyc = c; x.we = 3'b111; x.mepc = epc; x.mcause = 16'h8000 + 16'(16 + src);
        x.mstatus = {ms[15:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
        x.addr = 16'h0; x.asrt = 1'b0; x.ack = 8'h00;
        sb.push_back(x);
    endtask

    task automatic push_take(input int c, input int src, input logic [15:0] epc,
                             input logic [15:0] ms);
        exp_t x;
        push_save(c, src, epc, ms);
        x.cyc = c + 1; x.we = 3'b000; x.mepc = 16'h0; x.mcause = 16'h0; x.mstatus = 16'h0;
        x.addr = model_target(bus.csr_mtvec, src); x.asrt = 1'b1; x.ack = 8'(1 << src);
        sb.push_back(x);
    endtask

    task automatic push_mret(input int c, input logic [15:0] mepc, input logic [15:0] ms);
        exp_t x;
        x.cyc = c; x.we = 3'b001; x.mepc = 16'h0; x.mcause = 16'h0;
        x.mstatus = {ms[15:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
        x.addr = 16'h0; x.asrt = 1'b0; x.ack = 8'h00;
        sb.push_back(x);
        x.cyc = c + 1; x.we = 3'b000; x.mstatus = 16'h0; x.addr = mepc; x.asrt = 1'b1;
        sb.push_back(x);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, ".we"},      bus.int_we, 0);
        chk({pfx, ".mepc"},    bus.int_mepc, 0);
        chk({pfx, ".mcause"},  bus.int_mcause, 0);
        chk({pfx, ".mstatus"}, bus.int_mstatus, 0);
        chk({pfx, ".addr"},    bus.int_inst_addr, 0);
        chk({pfx, ".assert"},  bus.int_assert, 0);
        chk({pfx, ".ack"},     bus.irq_ack, 0);
        chk({pfx, ".clear"},   bus.clear_flag, 0);
        chk({pfx, ".pending"}, u_dut.pending, 0);
        chk({pfx, ".state"},   32'(u_dut.state), 0);
    endtask

    // scoreboard: every active output beat must match the head of the queue
    always @(negedge clk) begin
        if (bus.int_we != 3'b000 || bus.int_assert || bus.irq_ack != 8'h00) begin
            if (sb.size() == 0) begin
                chk("spurious_beat", {bus.int_we, bus.int_assert, bus.irq_ack}, 0);
            end else begin
                e = sb.pop_front();
                chk("beat.cyc",     cyc, e.cyc);
                chk("beat.we",      bus.int_we, e.we);
                chk("beat.mepc",    bus.int_mepc, e.mepc);
                chk("beat.mcause",  bus.int_mcause, e.mcause);
                chk("beat.mstatus", bus.int_mstatus, e.mstatus);
                chk("beat.addr",    bus.int_inst_addr, e.addr);
                chk("beat.assert",  bus.int_assert, e.asrt);
                chk("beat.ack",     bus.irq_ack, e.ack);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.irq = 8'h00; bus.irq_en = 8'hFF; bus.global_int_en = 1'b1;
        bus.inst_addr = 16'h0; bus.mret_flag = 1'b0; bus.jump_flag = 1'b0;
        bus.jump_addr = 16'h0; bus.csr_mtvec = 16'h0201; bus.csr_mepc = 16'h0;
        bus.csr_mstatus = 16'h0008;
        step(3);
        chk_quiet("reset");
        rst = 1'b0;
        step(1);

        // single source, pulse only one cycle
        bus.irq = 8'h04; bus.inst_addr = 16'h0040;
        push_take(cyc + 2, 2, 16'h0040, 16'h0008);
        step(1);
        bus.irq = 8'h00;
        step(6);

        // two sources in the same cycle: 1 first, 5 after returning to idle
        bus.irq = 8'h22; bus.inst_addr = 16'h0060;
        push_take(cyc + 2, 1, 16'h0060, 16'h0008);
        push_take(cyc + 5, 5, 16'h0060, 16'h0008);
        step(1);
        bus.irq = 8'h00;
        step(8);

        // EX redirect in the entry cycle supplies mepc
        bus.irq = 8'h01; bus.jump_flag = 1'b1; bus.jump_addr = 16'h0100; bus.inst_addr = 16'h0050;
        push_take(cyc + 2, 0, 16'h0100, 16'h0008);
        step(1);
        bus.irq = 8'h00;
        step(1);
        bus.jump_flag = 1'b0;
        step(6);

        // mret
        bus.csr_mepc = 16'h0040; bus.csr_mstatus = 16'h0080; bus.mret_flag = 1'b1;
        push_mret(cyc + 1, 16'h0040, 16'h0080);
        step(1);
        bus.mret_flag = 1'b0;
        step(5);

        // mret wins over a pending request; the request is taken afterwards
        bus.irq = 8'h08; bus.inst_addr = 16'h0070;
        step(1);
        bus.mret_flag = 1'b1;
        push_mret(cyc + 1, 16'h0040, 16'h0080);
        push_take(cyc + 4, 3, 16'h0070, 16'h0080);
        step(1);
        bus.mret_flag = 1'b0; bus.irq = 8'h00;
        step(8);

        // disabled source stays pending and is taken once enabled
        bus.csr_mstatus = 16'h0008; bus.irq_en = 8'hBF; bus.irq = 8'h40;
        step(1);
        bus.irq = 8'h00;
        step(5);
        bus.irq_en = 8'hFF;
        push_take(cyc + 1, 6, 16'h0070, 16'h0008);
        step(6);

        // global enable gates entry
        bus.global_int_en = 1'b0; bus.irq = 8'h10;
        step(1);
        bus.irq = 8'h00;
        step(4);
        bus.global_int_en = 1'b1;
        push_take(cyc + 1, 4, 16'h0070, 16'h0008);
        step(6);

        // non-vectored mode bits: target is the bare base in either build
        bus.csr_mtvec = 16'h0302; bus.irq = 8'h08;
        push_take(cyc + 2, 3, 16'h0070, 16'h0008);
        step(1);
        bus.irq = 8'h00;
        step(6);

        // reset during SAVE aborts the sequence
        bus.csr_mtvec = 16'h0201; bus.irq = 8'h80;
        push_save(cyc + 2, 7, 16'h0070, 16'h0008);
        step(2);
        rst = 1'b1; bus.irq = 8'h00;
        step(1);
        chk_quiet("midrst");
        rst = 1'b0;
        step(6);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
